// File: rtl/ex_multicycle_dispatch_if.sv
// Execute-stage dispatch bus: the pipeline side drives instruction/FU status,
// and the dispatcher returns start/kill pulses and completion status.
interface ex_multicycle_dispatch_if #(
  parameter int unsigned NUM_FU = 4
);
  logic              valid_i;
  logic [NUM_FU-1:0] fu_sel_i;
  logic [NUM_FU-1:0] fu_inhibit_i;
  logic              advance_i;
  logic              kill_i;
  logic [NUM_FU-1:0] fu_done_i;
  logic [NUM_FU-1:0] fu_start_o;
  logic [NUM_FU-1:0] fu_kill_o;
  logic              ex_done_o;
  logic              ex_busy_o;
  logic              timeout_o;
  logic [31:0]       busy_cycles_o;

  modport master (
    output valid_i, fu_sel_i, fu_inhibit_i, advance_i, kill_i, fu_done_i,
    input  fu_start_o, fu_kill_o, ex_done_o, ex_busy_o, timeout_o, busy_cycles_o
  );

  modport slave (
    input  valid_i, fu_sel_i, fu_inhibit_i, advance_i, kill_i, fu_done_i,
    output fu_start_o, fu_kill_o, ex_done_o, ex_busy_o, timeout_o, busy_cycles_o
  );
endinterface

// File: rtl/ex_multicycle_dispatch.sv
// EX-stage dispatch controller: pulses FU starts, tracks fixed-latency and
// handshake completions, aggregates them into ex_done, with kill and watchdog.
module ex_multicycle_dispatch #(
  parameter int unsigned         NUM_FU  = 4,
  parameter logic [4*NUM_FU-1:0] FU_LAT  = {4'd0, 4'd0, 4'd0, 4'd1},
  parameter int unsigned         TO_W    = 8,
  parameter int unsigned         TIMEOUT = 200
) (
  input logic                    clk,
  input logic                    rst_n,
  ex_multicycle_dispatch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [NUM_FU-1:0] pending_q, pending_d;
  logic [3:0]        cnt_q [NUM_FU];
  logic [TO_W-1:0]   to_q;
  logic [31:0]       busy_q;

  logic [NUM_FU-1:0] fixed_mask, lat1_mask, cnt_hit;
  logic [NUM_FU-1:0] eff, fin_start, pending_start, fin_wait, pending_left;
  logic              to_hit, load;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fixed_mask[i] = (FU_LAT[4*i +: 4] != 4'd0);
      lat1_mask[i]  = (FU_LAT[4*i +: 4] == 4'd1);
      cnt_hit[i]    = (cnt_q[i] == 4'd1);
    end
  end

  // Start-cycle completions: L=1 units, or handshake units answering at once.
  assign eff           = bus.fu_sel_i & ~bus.fu_inhibit_i;
  assign fin_start     = eff & (lat1_mask | (~fixed_mask & bus.fu_done_i));
  assign pending_start = eff & ~fin_start;
  assign fin_wait      = pending_q & ((fixed_mask & cnt_hit) | (~fixed_mask & bus.fu_done_i));
  assign pending_left  = pending_q & ~fin_wait;
  assign to_hit        = (to_q == TO_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: each combinational process assigns a default first so no path
  // leaves an output unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    if (!bus.valid_i || bus.kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (pending_start == '0) state_d = bus.advance_i ? IDLE : DONE;
                 else                     state_d = WAIT;
        WAIT:    if (pending_left == '0 || to_hit) state_d = bus.advance_i ? IDLE : DONE;
        DONE:    if (bus.advance_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.fu_start_o = '0;
    bus.fu_kill_o  = '0;
    bus.ex_done_o  = 1'b0;
    bus.timeout_o  = 1'b0;
    pending_d      = pending_q;
    load           = 1'b0;
    if (!bus.valid_i) begin
      bus.ex_done_o = 1'b1;
      pending_d     = '0;
      if (bus.kill_i) bus.fu_kill_o = pending_q;
    end else if (bus.kill_i) begin
      bus.fu_kill_o = pending_q;
      pending_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          bus.fu_start_o = eff;
          pending_d      = pending_start;
          bus.ex_done_o  = (pending_start == '0);
          load           = 1'b1;
        end
        WAIT: begin
          if (pending_left == '0) begin
            bus.ex_done_o = 1'b1;
            pending_d     = '0;
          end else if (to_hit) begin
            bus.timeout_o = 1'b1;
            bus.ex_done_o = 1'b1;
            bus.fu_kill_o = pending_q;
            pending_d     = '0;
          end else begin
            pending_d = pending_left;
          end
        end
        DONE:    bus.ex_done_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ex_busy_o     = (state_q == WAIT);
  assign bus.busy_cycles_o = busy_q;

  // NOTE: the latency counters are a handful of flops, so they take the
  // async reset like any other state rather than being left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      to_q      <= '0;
      busy_q    <= '0;
      for (int i = 0; i < NUM_FU; i++) cnt_q[i] <= 4'd0;
    end else begin
      pending_q <= pending_d;
      to_q      <= (state_q == WAIT) ? to_q + TO_W'(1) : '0;
      if (state_q == WAIT && busy_q != 32'hFFFF_FFFF) busy_q <= busy_q + 32'd1;
      for (int i = 0; i < NUM_FU; i++) begin
        if (load && eff[i])
          cnt_q[i] <= fixed_mask[i] ? FU_LAT[4*i +: 4] - 4'd1 : 4'd0;
        else if (state_q == WAIT && cnt_q[i] != 4'd0)
          cnt_q[i] <= cnt_q[i] - 4'd1;
      end
    end
  end

endmodule

// File: doc/ex_multicycle_dispatch.md
Name: ex_multicycle_dispatch

Overview:
Parametrised execute-stage dispatch controller for the RISC-V pipeline.
- Issues a one-cycle start pulse to each functional unit (FU) selected by the instruction in EX.
- Tracks completion of several concurrently selected FUs, including fixed-latency and handshake units.
- Aggregates completions into a single ex_done used by the hazard/stall logic.
- Adds kill (flush), watchdog timeout and a busy-cycle counter.

Parameters:
- NUM_FU, 4, number of functional units.
- FU_LAT, {4'd0,4'd0,4'd0,4'd1}, per-FU 4-bit latency packed LSB-first (FU0 = bits 3:0). 0 = handshake unit, completes on fu_done_i. L>=1 = fixed latency, done L-1 cycles after the start cycle (L=1 = same cycle).
- TO_W, 8, timeout counter width.
- TIMEOUT, 200, WAIT cycles before the watchdog fires (1..2^TO_W-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  EX holds a valid, implemented instruction
- fu_sel_i  in  NUM_FU  FUs required by the instruction; multi-hot allowed; 0 = no FU needed
- fu_inhibit_i  in  NUM_FU  per-FU start suppression (e.g. exception blocks LSU); an inhibited FU counts as done
- advance_i  in  1  EX pipeline register loads a new instruction this cycle
- kill_i  in  1  flush of the EX instruction
- fu_done_i  in  NUM_FU  completion pulses from handshake FUs
- fu_start_o  out  NUM_FU  one-cycle start pulses
- fu_kill_o  out  NUM_FU  one-cycle abort pulses to FUs still pending
- ex_done_o  out  1  instruction in EX complete (combinational)
- ex_busy_o  out  1  state == WAIT
- timeout_o  out  1  one-cycle watchdog pulse
- busy_cycles_o  out  32  saturating count of WAIT cycles since reset

Behaviour:
- Reset: state IDLE, pending mask 0, per-FU latency counters 0, timeout counter 0, busy_cycles_o 0.
- After reset, all outputs are 0 except ex_done_o = !valid_i.
- States are IDLE, WAIT and DONE.
- Bubble rule: valid_i=0 gives ex_done_o=1 and fu_start_o=0 in every state. Next state is IDLE and the pending mask is cleared.
- Start: in IDLE with valid_i=1 and kill_i=0:
  - eff = fu_sel_i & ~fu_inhibit_i;
  - fu_start_o = eff for exactly that cycle.
  - Pending is loaded with the FUs of eff not completing this cycle.
  - A FU completes this cycle if it is L=1, or if it is L=0 with fu_done_i set in the same cycle.
- Fixed FU with L>=2: its counter is loaded with L-1 at start, decrements each cycle in WAIT, and the FU completes when the counter reaches 1.
- Handshake FU: completes on fu_done_i while its pending bit is set. fu_done_i for non-pending FUs is ignored.
- ex_done_o = 1 in the cycle the last pending bit clears, or in the start cycle if nothing remains pending (including eff=0).
- Transitions:
  - IDLE -> DONE when ex_done_o fires in the start cycle.
  - IDLE -> WAIT otherwise.
  - WAIT -> DONE when ex_done_o fires.
  - DONE -> IDLE on advance_i or !valid_i.
- DONE holds ex_done_o=1 and never re-pulses fu_start_o, even if the pipeline is stalled downstream.
- advance_i in the same cycle as ex_done_o (from WAIT or the start cycle) goes straight to IDLE, so the next instruction starts the following cycle.
- Kill: kill_i=1 in any state:
  - fu_kill_o = current pending mask, for one cycle;
  - pending is cleared, next state is IDLE;
  - ex_done_o is forced to 0 that cycle, except the bubble rule still applies;
  - fu_start_o is forced to 0.
- Kill wins over a simultaneous fu_done_i or timeout.
- Timeout counter: cleared on entry to WAIT, increments each WAIT cycle. When it equals TIMEOUT-1 and completion has not occurred:
  - timeout_o=1, ex_done_o=1, fu_kill_o = pending;
  - pending is cleared, next state is DONE.
- Completion in the same cycle as timeout: normal done, timeout_o=0.
- busy_cycles_o increments each WAIT cycle and saturates at 32'hFFFFFFFF.
- Overflow rule: no cross-FU ordering is assumed; done pulses may arrive in any order and in the same cycle.

Test Plan:
- Single-cycle FU: FU_LAT[0]=1, fu_sel_i=0001, valid_i=1 → fu_start_o=0001 and ex_done_o=1 in the same cycle. With advance_i=0 held 3 cycles: no second start, ex_done_o stays 1.
- Mixed completion: fu_sel_i=0110, FU1 fixed L=3, FU2 handshake with fu_done_i[2] at cycle +5 → ex_done_o only at cycle +5. ex_busy_o=1 from cycles +1..+5 (high during the +5 completion cycle, low from +6), busy_cycles_o=5.
- Inhibit: fu_sel_i=1001, fu_inhibit_i=1000, FU0 L=1 → fu_start_o=0001, ex_done_o=1 in the start cycle. fu_sel_i=1000 with fu_inhibit_i=1000 → no start, done immediately.
- Kill mid-WAIT: handshake FU3 started, kill_i at cycle +2 together with fu_done_i[3] → fu_kill_o=1000, ex_done_o=0, state IDLE. The next valid instruction starts the following cycle.
- Timeout: TIMEOUT=8, handshake FU never responds → timeout_o and ex_done_o pulse at the 8th WAIT cycle, fu_kill_o=pending. Done at the same cycle instead → timeout_o=0.
- Bubble and reset: valid_i=0 gives ex_done_o=1 with no starts. Asserting rst_n=0 mid-WAIT clears pending; after release there is no spurious start, and busy_cycles_o=0.
